bcd_counter_chain: RTL and testbench

- Parametrised multi-digit modulo-M counter (default: 4-digit decade/BCD). Successor to the single-digit decade counter with enable.
- Adds up/down counting, synchronous clear, parallel load with digit validation, ripple-free look-ahead carry between digits, and a registered wrap pulse.
- Used as the event/time-base counter feeding display and timer logic.

---
 rtl/bcd_counter_chain_pkg.sv | 29 ++
 rtl/bcd_counter_chain_digit.sv | 61 ++++++
 rtl/bcd_counter_chain.sv | 94 +++++++++
 tb/tb_bcd_counter_chain.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_chain_pkg.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain_pkg
// Shared constants and helpers for the multi-digit modulo-M counter chain.
//   DEF_DIGITS / DEF_MODULUS / DEF_DW : default chain geometry (4-digit BCD)
//   dir_e                             : count direction encoding on up_dn
//   bits_for_modulus()                : minimum digit width for a modulus
// ---------------------------------------------------------------------------
package bcd_counter_chain_pkg;

    localparam int unsigned DEF_DIGITS  = 4;
    localparam int unsigned DEF_MODULUS = 10;
    localparam int unsigned DEF_DW      = 4;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Smallest width b (>= 1) with 2**b >= modulus.
    function automatic int unsigned bits_for_modulus(input int unsigned modulus);
        for (int unsigned b = 1; b < 32; b++) begin
            if ((32'd1 << b) >= modulus) begin
                return b;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_digit.sv
// ---------------------------------------------------------------------------
// counter_digit
// One modulo-MODULUS up/down digit of the counter chain.
//   clk, rst      : clock (rising edge), async active-high reset
//   clr           : synchronous clear to 0 (highest priority)
//   load          : synchronous load of load_digit (illegal values load as 0)
//   load_digit    : candidate digit value for load
//   step_en       : step this digit on this edge (look-ahead enable from top)
//   up_dn         : 1 = increment, 0 = decrement
//   digit         : current digit value, always 0..MODULUS-1
//   at_max        : digit == MODULUS-1
//   at_zero       : digit == 0
//   load_illegal  : load_digit >= MODULUS (combinational)
// ---------------------------------------------------------------------------
module counter_digit
    import bcd_counter_chain_pkg::*;
#(
    parameter int unsigned MODULUS = DEF_MODULUS,
    parameter int unsigned DW      = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step_en,
    input  logic          up_dn,
    output logic [DW-1:0] digit,
    output logic          at_max,
    output logic          at_zero,
    output logic          load_illegal
);

    localparam logic [DW-1:0] MAX_VAL = DW'(MODULUS - 1);
    localparam logic [DW-1:0] ONE     = DW'(1);
    // One extra bit so MODULUS == 2**DW is representable in the compare.
    localparam logic [DW:0]   MOD_EXT = (DW + 1)'(MODULUS);

    assign at_max       = (digit == MAX_VAL);
    assign at_zero      = (digit == '0);
    assign load_illegal = ({1'b0, load_digit} >= MOD_EXT);

    // Wrap is decided by explicit compare, never by binary overflow, so
    // MODULUS < 2**DW and MODULUS == 2**DW behave the same way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_illegal ? '0 : load_digit;
        end else if (step_en) begin
            if (up_dn == DIR_UP) begin
                digit <= at_max ? '0 : digit + ONE;
            end else begin
                digit <= at_zero ? MAX_VAL : digit - ONE;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_chain.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain
// Parametrised multi-digit modulo-M up/down counter with look-ahead carry.
//   clk, rst  : clock (rising edge), async active-high reset
//   en        : count enable, one step per clock while high
//   up_dn     : 1 = count up, 0 = count down
//   clr       : synchronous clear (priority clr > load > en)
//   load      : synchronous parallel load of load_val
//   load_val  : digit i at [i*DW +: DW], digit 0 least significant
//   q         : current count, same packing as load_val
//   tc        : terminal count for the current direction (not gated by en)
//   carry     : tc & en, cascades to a following chain
//   wrap      : one-cycle pulse in the cycle after a full wrap step
//   load_err  : one-cycle pulse in the cycle after a load with illegal digit(s)
// ---------------------------------------------------------------------------
module bcd_counter_chain
    import bcd_counter_chain_pkg::*;
#(
    parameter int unsigned DIGITS  = DEF_DIGITS,
    parameter int unsigned MODULUS = DEF_MODULUS,
    parameter int unsigned DW      = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] q,
    output logic                 tc,
    output logic                 carry,
    output logic                 wrap,
    output logic                 load_err
);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter_chain: DIGITS must be 1..8");
    end
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
        $error("bcd_counter_chain: MODULUS must be 2..16");
    end
    if (DW < bits_for_modulus(MODULUS)) begin : g_bad_dw
        $error("bcd_counter_chain: DW too narrow for MODULUS");
    end

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] illegal;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        // Mask of digits below i; each digit's enable is one flat AND over
        // the lower terminal flags rather than a ripple through neighbours.
        localparam logic [DIGITS-1:0] LOWER = DIGITS'((64'd1 << i) - 64'd1);

        assign term[i]    = (up_dn == DIR_UP) ? at_max[i] : at_zero[i];
        assign step_en[i] = en & (&(term | ~LOWER));

        counter_digit #(
            .MODULUS (MODULUS),
            .DW      (DW)
        ) u_digit (
            .clk          (clk),
            .rst          (rst),
            .clr          (clr),
            .load         (load),
            .load_digit   (load_val[i*DW +: DW]),
            .step_en      (step_en[i]),
            .up_dn        (up_dn),
            .digit        (q[i*DW +: DW]),
            .at_max       (at_max[i]),
            .at_zero      (at_zero[i]),
            .load_illegal (illegal[i])
        );
    end

    assign tc    = &term;
    assign carry = tc & en;

    // A counting step with every digit terminal is exactly a wrap step;
    // clr and load pre-empt counting, so they suppress the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= ~clr & ~load & carry;
            load_err <= ~clr & load & (|illegal);
        end
    end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_chain
// Directed, table-driven bench for bcd_counter_chain. Three instances:
//   u_d2 : DIGITS=2, MODULUS=10, DW=4 (BCD 00..99)
//   u_d3 : DIGITS=3, MODULUS=16, DW=4 (hex 000..FFF)
//   u_d1 : DIGITS=1, MODULUS=2,  DW=1 (back-to-back wraps)
// Each vector: drive inputs, check tc/carry before the edge, clock, then
// check q/wrap/load_err one time unit after the edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_counter_chain;

    typedef struct {
        logic        en;
        logic        up;
        logic        clr;
        logic        ld;
        logic [11:0] val;
        logic [11:0] q;
        logic        tc;
        logic        c;
        logic        w;
        logic        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic en2 = 0, up2 = 0, clr2 = 0, ld2 = 0;
    logic [7:0]  lv2 = '0;
    logic [7:0]  q2;
    logic tc2, c2, w2, e2;

    logic en3 = 0, up3 = 0, clr3 = 0, ld3 = 0;
    logic [11:0] lv3 = '0;
    logic [11:0] q3;
    logic tc3, c3, w3, e3;

    logic en1 = 0, up1 = 0, clr1 = 0, ld1 = 0;
    logic [0:0]  lv1 = '0;
    logic [0:0]  q1;
    logic tc1, c1, w1, e1;

    bcd_counter_chain #(.DIGITS(2), .MODULUS(10), .DW(4)) u_d2 (
        .clk(clk), .rst(rst), .en(en2), .up_dn(up2), .clr(clr2), .load(ld2),
        .load_val(lv2), .q(q2), .tc(tc2), .carry(c2), .wrap(w2), .load_err(e2));

    bcd_counter_chain #(.DIGITS(3), .MODULUS(16), .DW(4)) u_d3 (
        .clk(clk), .rst(rst), .en(en3), .up_dn(up3), .clr(clr3), .load(ld3),
        .load_val(lv3), .q(q3), .tc(tc3), .carry(c3), .wrap(w3), .load_err(e3));

    bcd_counter_chain #(.DIGITS(1), .MODULUS(2), .DW(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en1), .up_dn(up1), .clr(clr1), .load(ld1),
        .load_val(lv1), .q(q1), .tc(tc1), .carry(c1), .wrap(w1), .load_err(e1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic up, input logic clr,
                                input logic ld, input logic [11:0] val,
                                input logic [11:0] q, input logic tc, input logic c,
                                input logic w, input logic e);
        vec_t v;
        v.en = en; v.up = up; v.clr = clr; v.ld = ld; v.val = val;
        v.q = q; v.tc = tc; v.c = c; v.w = w; v.e = e;
        return v;
    endfunction

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic apply(input int inst, input vec_t v, input string tag);
        case (inst)
            2: begin en2 = v.en; up2 = v.up; clr2 = v.clr; ld2 = v.ld; lv2 = v.val[7:0]; end
            3: begin en3 = v.en; up3 = v.up; clr3 = v.clr; ld3 = v.ld; lv3 = v.val; end
            default: begin en1 = v.en; up1 = v.up; clr1 = v.clr; ld1 = v.ld; lv1 = v.val[0:0]; end
        endcase
        #1;
        case (inst)
            2: begin chk({tag, " tc"}, 12'(tc2), 12'(v.tc)); chk({tag, " carry"}, 12'(c2), 12'(v.c)); end
            3: begin chk({tag, " tc"}, 12'(tc3), 12'(v.tc)); chk({tag, " carry"}, 12'(c3), 12'(v.c)); end
            default: begin chk({tag, " tc"}, 12'(tc1), 12'(v.tc)); chk({tag, " carry"}, 12'(c1), 12'(v.c)); end
        endcase
        @(posedge clk);
        #1;
        case (inst)
            2: begin
                chk({tag, " q"}, 12'(q2), v.q);
                chk({tag, " wrap"}, 12'(w2), 12'(v.w));
                chk({tag, " load_err"}, 12'(e2), 12'(v.e));
            end
            3: begin
                chk({tag, " q"}, q3, v.q);
                chk({tag, " wrap"}, 12'(w3), 12'(v.w));
                chk({tag, " load_err"}, 12'(e3), 12'(v.e));
            end
            default: begin
                chk({tag, " q"}, 12'(q1), v.q);
                chk({tag, " wrap"}, 12'(w1), 12'(v.w));
                chk({tag, " load_err"}, 12'(e1), 12'(v.e));
            end
        endcase
    endtask

    vec_t v2[17];
    vec_t v3[9];
    vec_t v1[5];

    initial begin
        int n;
        int prev;

        //                en up clr ld val     q      tc c  w  e
        v2[0]  = mk(0, 1, 0, 1, 12'h03C, 12'h030, 1, 0, 0, 1);
        v2[1]  = mk(0, 1, 0, 1, 12'h027, 12'h027, 0, 0, 0, 0);
        v2[2]  = mk(0, 1, 0, 0, 12'h000, 12'h027, 0, 0, 0, 0);
        v2[3]  = mk(1, 1, 0, 1, 12'h057, 12'h057, 0, 0, 0, 0);
        v2[4]  = mk(1, 1, 1, 1, 12'h011, 12'h000, 0, 0, 0, 0);
        v2[5]  = mk(1, 1, 0, 0, 12'h000, 12'h001, 0, 0, 0, 0);
        v2[6]  = mk(0, 1, 0, 1, 12'h0AA, 12'h000, 0, 0, 0, 1);
        v2[7]  = mk(0, 1, 0, 1, 12'h09F, 12'h090, 0, 0, 0, 1);
        v2[8]  = mk(1, 0, 0, 1, 12'h0F9, 12'h009, 0, 0, 0, 1);
        v2[9]  = mk(1, 0, 0, 0, 12'h000, 12'h008, 0, 0, 0, 0);
        v2[10] = mk(0, 1, 0, 1, 12'h099, 12'h099, 0, 0, 0, 0);
        v2[11] = mk(1, 1, 1, 0, 12'h000, 12'h000, 1, 1, 0, 0);
        v2[12] = mk(1, 0, 0, 0, 12'h000, 12'h099, 1, 1, 1, 0);
        v2[13] = mk(0, 1, 0, 0, 12'h000, 12'h099, 1, 0, 0, 0);
        v2[14] = mk(1, 1, 0, 1, 12'h099, 12'h099, 1, 1, 0, 0);
        v2[15] = mk(1, 0, 0, 0, 12'h000, 12'h098, 0, 0, 0, 0);
        v2[16] = mk(1, 1, 1, 1, 12'h0A5, 12'h000, 0, 0, 0, 0);

        v3[0] = mk(0, 1, 0, 1, 12'hFFE, 12'hFFE, 0, 0, 0, 0);
        v3[1] = mk(1, 1, 0, 0, 12'h000, 12'hFFF, 0, 0, 0, 0);
        v3[2] = mk(0, 1, 0, 0, 12'h000, 12'hFFF, 1, 0, 0, 0);
        v3[3] = mk(0, 1, 0, 0, 12'h000, 12'hFFF, 1, 0, 0, 0);
        v3[4] = mk(1, 1, 0, 0, 12'h000, 12'h000, 1, 1, 1, 0);
        v3[5] = mk(1, 1, 0, 0, 12'h000, 12'h001, 0, 0, 0, 0);
        v3[6] = mk(1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        v3[7] = mk(1, 0, 0, 0, 12'h000, 12'hFFF, 1, 1, 1, 0);
        v3[8] = mk(1, 0, 0, 0, 12'h000, 12'hFFE, 0, 0, 0, 0);

        v1[0] = mk(1, 1, 0, 0, 12'h000, 12'h001, 0, 0, 0, 0);
        v1[1] = mk(1, 1, 0, 0, 12'h000, 12'h000, 1, 1, 1, 0);
        v1[2] = mk(1, 0, 0, 0, 12'h000, 12'h001, 1, 1, 1, 0);
        v1[3] = mk(1, 1, 0, 0, 12'h000, 12'h000, 1, 1, 1, 0);
        v1[4] = mk(0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

        // Reset state
        #12;
        chk("reset q2", 12'(q2), 12'h000);
        chk("reset wrap2", 12'(w2), 12'h0);
        chk("reset err2", 12'(e2), 12'h0);
        chk("reset q3", q3, 12'h000);
        chk("reset q1", 12'(q1), 12'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full up count 00..99 -> 00
        n = 0;
        for (int k = 0; k < 100; k++) begin
            en2 = 1; up2 = 1;
            #1;
            chk("up tc", 12'(tc2), 12'(n == 99));
            chk("up carry", 12'(c2), 12'(n == 99));
            @(posedge clk);
            #1;
            prev = n;
            n = (n + 1) % 100;
            chk("up q", 12'(q2), 12'(bcd2(n)));
            chk("up wrap", 12'(w2), 12'(prev == 99));
        end

        // Load 45 then count down 46 steps to 99
        apply(2, mk(0, 0, 0, 1, 12'h045, 12'h045, 1, 0, 0, 0), "load45");
        n = 45;
        for (int k = 0; k < 46; k++) begin
            en2 = 1; up2 = 0; ld2 = 0;
            #1;
            chk("dn tc", 12'(tc2), 12'(n == 0));
            chk("dn carry", 12'(c2), 12'(n == 0));
            @(posedge clk);
            #1;
            prev = n;
            n = (n + 99) % 100;
            chk("dn q", 12'(q2), 12'(bcd2(n)));
            chk("dn wrap", 12'(w2), 12'(prev == 0));
        end

        for (int i = 0; i < 17; i++) begin
            apply(2, v2[i], $sformatf("v2[%0d]", i));
        end

        // Async reset while load_err is high
        apply(2, mk(0, 1, 0, 1, 12'h0E3, 12'h003, 0, 0, 0, 1), "loadE3");
        #2 rst = 1'b1;
        #1;
        chk("arst1 q", 12'(q2), 12'h000);
        chk("arst1 err", 12'(e2), 12'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset mid-count at 63
        apply(2, mk(0, 1, 0, 1, 12'h062, 12'h062, 0, 0, 0, 0), "load62");
        apply(2, mk(1, 1, 0, 0, 12'h000, 12'h063, 0, 0, 0, 0), "cnt63");
        #2 rst = 1'b1;
        #1;
        chk("arst2 q", 12'(q2), 12'h000);
        chk("arst2 wrap", 12'(w2), 12'h0);
        chk("arst2 err", 12'(e2), 12'h0);
        @(posedge clk);
        #1;
        chk("arst2 held q", 12'(q2), 12'h000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst2 resume q", 12'(q2), 12'h001);
        en2 = 0;

        for (int i = 0; i < 9; i++) begin
            apply(3, v3[i], $sformatf("v3[%0d]", i));
        end
        for (int i = 0; i < 5; i++) begin
            apply(1, v1[i], $sformatf("v1[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
